// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-register stages: default field widths,
// the skid-buffer state encoding and the packed payload-width helper.
package pipe_pkg;

  localparam int DEF_ALUOP_W  = 7;
  localparam int DEF_ALUSEL_W = 3;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_RADDR_W  = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  function automatic int payload_w(input int aluop_w, input int alusel_w,
                                   input int data_w, input int raddr_w);
    return aluop_w + alusel_w + 2 * data_w + raddr_w + 1;
  endfunction

  localparam int DEF_PAYLOAD_W =
    payload_w(DEF_ALUOP_W, DEF_ALUSEL_W, DEF_DATA_W, DEF_RADDR_W);

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry valid/ready skid buffer with registered upstream ready, synchronous
// flush and an all-zero payload whenever the output side is empty.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int W = DEF_PAYLOAD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  pipe_state_e  r_state, w_state_nxt;
  logic [W-1:0] r_main, r_skid, w_main_nxt, w_skid_nxt;
  logic         r_valid, r_ready;
  logic         w_accept, w_pop;

  assign w_accept = i_valid && r_ready;
  assign w_pop    = r_valid && i_ready;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (i_flush) begin
      w_state_nxt = EMPTY;
      w_main_nxt  = '0;
      w_skid_nxt  = '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_state_nxt = BUSY;
            w_main_nxt  = i_data;
          end
        end
        BUSY: begin
          if (w_accept && w_pop) begin
            w_main_nxt = i_data;
          end else if (w_accept) begin
            w_state_nxt = FULL;
            w_skid_nxt  = i_data;
          end else if (w_pop) begin
            w_state_nxt = EMPTY;
            w_main_nxt  = '0;
          end
        end
        FULL: begin
          if (w_pop) begin
            w_state_nxt = BUSY;
            w_main_nxt  = r_skid;
            w_skid_nxt  = '0;
          end
        end
        default: begin
          w_state_nxt = EMPTY;
          w_main_nxt  = '0;
          w_skid_nxt  = '0;
        end
      endcase
    end
  end

  // NOTE: the data entries are reset too, because an empty stage must present an
  // all-zero bubble; sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
      r_valid <= (w_state_nxt != EMPTY);
      r_ready <= (w_state_nxt != FULL);
    end
  end

  assign o_valid = r_valid;
  assign o_ready = r_ready;
  assign o_data  = r_main;

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register: packs decode fields into a skid buffer and keeps a
// saturating count of cycles where decode was held off.
module id_ex_pipe
  import pipe_pkg::*;
#(
  parameter int ALUOP_W     = DEF_ALUOP_W,
  parameter int ALUSEL_W    = DEF_ALUSEL_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int RADDR_W     = DEF_RADDR_W,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   id_valid,
  output logic                   id_ready,
  input  logic [ALUOP_W-1:0]     id_aluop,
  input  logic [ALUSEL_W-1:0]    id_alusel,
  input  logic [DATA_W-1:0]      id_reg1,
  input  logic [DATA_W-1:0]      id_reg2,
  input  logic [RADDR_W-1:0]     id_wd,
  input  logic                   id_wreg,
  output logic                   ex_valid,
  input  logic                   ex_ready,
  output logic [ALUOP_W-1:0]     ex_aluop,
  output logic [ALUSEL_W-1:0]    ex_alusel,
  output logic [DATA_W-1:0]      ex_reg1,
  output logic [DATA_W-1:0]      ex_reg2,
  output logic [RADDR_W-1:0]     ex_wd,
  output logic                   ex_wreg,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int PW = payload_w(ALUOP_W, ALUSEL_W, DATA_W, RADDR_W);

  logic [PW-1:0]          w_id_payload, w_ex_payload;
  logic                   w_id_ready;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  assign w_id_payload = {id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg};

  pipe_skid_buf #(.W(PW)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_valid (id_valid),
    .o_ready (w_id_ready),
    .i_data  (w_id_payload),
    .o_valid (ex_valid),
    .i_ready (ex_ready),
    .o_data  (w_ex_payload)
  );

  assign {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg} = w_ex_payload;
  assign id_ready = w_id_ready;

  // Counts flush cycles too; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (id_valid && !w_id_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: directed vector table, streaming/saturation sequences and
// randomized traffic checked against a queue-based reference model.
module tb_id_ex_pipe;

  typedef struct packed {
    logic [6:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  wd;
    logic        wreg;
  } pl_t;

  typedef struct {
    logic        rst_n;
    logic        flush;
    logic        id_valid;
    logic        ex_ready;
    logic [31:0] reg1;
    logic        wreg;
    logic        exp_valid;
    logic        exp_ready;
    logic [31:0] exp_reg1;
    logic [15:0] exp_stall;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, id_valid, ex_ready, id_wreg;
  logic [6:0]  id_aluop;
  logic [2:0]  id_alusel;
  logic [31:0] id_reg1, id_reg2;
  logic [4:0]  id_wd;

  logic        id_ready, ex_valid, ex_wreg;
  logic [6:0]  ex_aluop;
  logic [2:0]  ex_alusel;
  logic [31:0] ex_reg1, ex_reg2;
  logic [4:0]  ex_wd;
  logic [15:0] stall_cnt;

  logic        s_id_ready, s_ex_valid, s_ex_wreg;
  logic [6:0]  s_ex_aluop;
  logic [2:0]  s_ex_alusel;
  logic [31:0] s_ex_reg1, s_ex_reg2;
  logic [4:0]  s_ex_wd;
  logic [2:0]  s_stall_cnt;

  always #5 clk = ~clk;

  id_ex_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_aluop(id_aluop), .id_alusel(id_alusel), .id_reg1(id_reg1), .id_reg2(id_reg2),
    .id_wd(id_wd), .id_wreg(id_wreg),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_aluop(ex_aluop), .ex_alusel(ex_alusel), .ex_reg1(ex_reg1), .ex_reg2(ex_reg2),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .stall_cnt(stall_cnt)
  );

  id_ex_pipe #(.STALL_CNT_W(3)) dut_small (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .id_valid(id_valid), .id_ready(s_id_ready),
    .id_aluop(id_aluop), .id_alusel(id_alusel), .id_reg1(id_reg1), .id_reg2(id_reg2),
    .id_wd(id_wd), .id_wreg(id_wreg),
    .ex_valid(s_ex_valid), .ex_ready(ex_ready),
    .ex_aluop(s_ex_aluop), .ex_alusel(s_ex_alusel), .ex_reg1(s_ex_reg1), .ex_reg2(s_ex_reg2),
    .ex_wd(s_ex_wd), .ex_wreg(s_ex_wreg), .stall_cnt(s_stall_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the stage is a FIFO holding at most two instructions.
  pl_t q[$];
  int  m_cnt_big   = 0;
  int  m_cnt_small = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    bit   m_ready, m_valid, acc, pop;
    pl_t  in_pl;
    m_ready = (q.size() < 2);
    m_valid = (q.size() > 0);
    acc     = id_valid && m_ready;
    pop     = m_valid && ex_ready;
    in_pl   = '{id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg};
    if (!rst_n) begin
      q.delete();
      m_cnt_big   = 0;
      m_cnt_small = 0;
    end else begin
      if (id_valid && !m_ready) begin
        if (m_cnt_big < 65535) m_cnt_big++;
        if (m_cnt_small < 7) m_cnt_small++;
      end
      if (flush) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(in_pl);
      end
    end
  endtask

  task automatic compare_model();
    pl_t exp_pl, act_pl, act_s;
    exp_pl = (q.size() > 0) ? q[0] : '0;
    act_pl = '{ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg};
    act_s  = '{s_ex_aluop, s_ex_alusel, s_ex_reg1, s_ex_reg2, s_ex_wd, s_ex_wreg};
    check("ex_valid",      128'(ex_valid),    128'(q.size() > 0));
    check("id_ready",      128'(id_ready),    128'(q.size() < 2));
    check("ex_payload",    128'(act_pl),      128'(exp_pl));
    check("stall_cnt",     128'(stall_cnt),   128'(m_cnt_big));
    check("small_payload", 128'(act_s),       128'(exp_pl));
    check("small_stall",   128'(s_stall_cnt), 128'(m_cnt_small));
  endtask

  task automatic apply();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic drive(input logic r, input logic f, input logic v, input logic rdy,
                       input logic [31:0] r1, input logic [4:0] wd, input logic wr);
    rst_n     = r;
    flush     = f;
    id_valid  = v;
    ex_ready  = rdy;
    id_aluop  = 7'h21;
    id_alusel = 3'h2;
    id_reg1   = r1;
    id_reg2   = ~r1;
    id_wd     = wd;
    id_wreg   = wr;
  endtask

  function automatic vec_t mkv(input logic r, input logic f, input logic v, input logic rdy,
                               input logic [31:0] r1, input logic wr, input logic ev,
                               input logic er, input logic [31:0] e1, input logic [15:0] es);
    vec_t t;
    t.rst_n = r;  t.flush = f;  t.id_valid = v;  t.ex_ready = rdy;
    t.reg1 = r1;  t.wreg = wr;  t.exp_valid = ev; t.exp_ready = er;
    t.exp_reg1 = e1; t.exp_stall = es;
    return t;
  endfunction

  vec_t vt[17];

  initial begin
    // Reset, backpressure A/B/C, flush in FULL, mid-stream reset.
    vt[0]  = mkv(0, 0, 1, 0, 32'h21, 1, 0, 1, 32'h0,  16'd0);
    vt[1]  = mkv(0, 0, 1, 0, 32'h21, 1, 0, 1, 32'h0,  16'd0);
    vt[2]  = mkv(1, 0, 1, 0, 32'hA,  1, 1, 1, 32'hA,  16'd0);
    vt[3]  = mkv(1, 0, 1, 0, 32'hB,  1, 1, 0, 32'hA,  16'd0);
    vt[4]  = mkv(1, 0, 1, 0, 32'hC,  1, 1, 0, 32'hA,  16'd1);
    vt[5]  = mkv(1, 0, 1, 0, 32'hC,  1, 1, 0, 32'hA,  16'd2);
    vt[6]  = mkv(1, 0, 1, 1, 32'hC,  1, 1, 1, 32'hB,  16'd3);
    vt[7]  = mkv(1, 0, 1, 1, 32'hC,  1, 1, 1, 32'hC,  16'd3);
    vt[8]  = mkv(1, 0, 0, 1, 32'h0,  0, 0, 1, 32'h0,  16'd3);
    vt[9]  = mkv(1, 0, 1, 0, 32'hD,  1, 1, 1, 32'hD,  16'd3);
    vt[10] = mkv(1, 0, 1, 0, 32'hE,  1, 1, 0, 32'hD,  16'd3);
    vt[11] = mkv(1, 1, 1, 0, 32'hF,  1, 0, 1, 32'h0,  16'd4);
    vt[12] = mkv(1, 0, 0, 1, 32'h0,  0, 0, 1, 32'h0,  16'd4);
    vt[13] = mkv(1, 0, 1, 0, 32'h11, 1, 1, 1, 32'h11, 16'd4);
    vt[14] = mkv(0, 0, 1, 0, 32'h12, 1, 0, 1, 32'h0,  16'd0);
    vt[15] = mkv(1, 0, 1, 1, 32'h13, 1, 1, 1, 32'h13, 16'd0);
    vt[16] = mkv(1, 0, 0, 1, 32'h0,  0, 0, 1, 32'h0,  16'd0);

    drive(0, 0, 0, 0, 32'h0, 5'h0, 0);
    #1;
    for (int i = 0; i < 17; i++) begin
      drive(vt[i].rst_n, vt[i].flush, vt[i].id_valid, vt[i].ex_ready,
            vt[i].reg1, vt[i].reg1[4:0], vt[i].wreg);
      apply();
      check($sformatf("vec%0d_valid", i), 128'(ex_valid),  128'(vt[i].exp_valid));
      check($sformatf("vec%0d_ready", i), 128'(id_ready),  128'(vt[i].exp_ready));
      check($sformatf("vec%0d_reg1", i),  128'(ex_reg1),   128'(vt[i].exp_reg1));
      check($sformatf("vec%0d_stall", i), 128'(stall_cnt), 128'(vt[i].exp_stall));
      if (!vt[i].exp_valid) begin
        check($sformatf("vec%0d_bubble_wreg", i), 128'(ex_wreg), 128'(0));
        check($sformatf("vec%0d_bubble_wd", i),   128'(ex_wd),   128'(0));
      end
    end

    // Saturation: two instructions fill the stage, then 18 stalled cycles.
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 1, 0, 32'h100 + i, 5'd3, 1);
      apply();
    end
    check("sat_small_stall", 128'(s_stall_cnt), 128'(7));
    check("sat_big_stall",   128'(stall_cnt),   128'(18));
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 1, 32'h0, 5'd0, 0);
      apply();
    end
    check("drained_valid", 128'(ex_valid), 128'(0));

    // Streaming: back-to-back instructions, one per cycle.
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 1, 1, 32'(i), 5'(i + 1), 1);
      apply();
      check($sformatf("stream%0d_reg1", i),  128'(ex_reg1),  128'(i));
      check($sformatf("stream%0d_wd", i),    128'(ex_wd),    128'(i + 1));
      check($sformatf("stream%0d_ready", i), 128'(id_ready), 128'(1));
      check($sformatf("stream%0d_valid", i), 128'(ex_valid), 128'(1));
    end
    drive(1, 0, 0, 1, 32'h0, 5'd0, 0);
    apply();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 59) != 0), ($urandom_range(0, 24) == 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
            $urandom, 5'($urandom), 1'($urandom));
      id_aluop  = 7'($urandom);
      id_alusel = 3'($urandom);
      id_reg2   = $urandom;
      apply();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- Next-generation ID/EX pipeline register with parametrised field widths.
- Adds a valid/ready handshake, a two-entry skid buffer so upstream ready is fully registered, synchronous flush, and a saturating stall-cycle counter.
- Sits between the decode stage (id_*) and the execute stage (ex_*).
- An empty stage presents a NOP bubble: all ex_* payload fields are zero.

Parameters:
- ALUOP_W, 7, width of id_aluop/ex_aluop.
- ALUSEL_W, 3, width of id_alusel/ex_alusel.
- DATA_W, 32, width of reg1/reg2 operands.
- RADDR_W, 5, width of the destination register address.
- STALL_CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, synchronous, active-low; sampled on the rising edge of clk.
- flush  in  1  synchronous pipeline flush (branch/exception squash).
- id_valid  in  1  decode presents a valid instruction.
- id_ready  out  1  stage can accept; a registered output.
- id_aluop  in  ALUOP_W  ALU operation.
- id_alusel  in  ALUSEL_W  ALU result-select class.
- id_reg1  in  DATA_W  source operand 1.
- id_reg2  in  DATA_W  source operand 2.
- id_wd  in  RADDR_W  destination register address.
- id_wreg  in  1  destination write enable.
- ex_valid  out  1  execute-side payload is valid.
- ex_ready  in  1  execute consumes the payload this cycle.
- ex_aluop  out  ALUOP_W  registered payload field.
- ex_alusel  out  ALUSEL_W  registered payload field.
- ex_reg1  out  DATA_W  registered payload field.
- ex_reg2  out  DATA_W  registered payload field.
- ex_wd  out  RADDR_W  registered payload field.
- ex_wreg  out  1  registered payload field.
- stall_cnt  out  STALL_CNT_W  saturating count of cycles with id_valid && !id_ready.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=EMPTY, ex_valid=0, id_ready=1.
  - All ex_* payload=0, skid entry cleared, stall_cnt=0.
  - Reset takes priority over flush and all traffic.
- Handshake events:
  - accept = id_valid && id_ready.
  - pop = ex_valid && ex_ready.
  - A payload transfers on the same cycle as its handshake; there is no combinational path from ex_ready to id_ready.
- Storage: a main entry (drives ex_*) and a skid entry.
- States and transitions:
  - EMPTY (ex_valid=0, id_ready=1): accept -> BUSY, main<=id payload.
  - BUSY (ex_valid=1, id_ready=1):
    - accept&&pop -> BUSY, main<=id payload.
    - accept&&!pop -> FULL, skid<=id payload, main holds.
    - !accept&&pop -> EMPTY, main payload zeroed.
    - otherwise hold.
  - FULL (ex_valid=1, id_ready=0):
    - pop -> BUSY, main<=skid, skid cleared.
    - otherwise hold.
    - id_* is ignored in FULL.
- Latency and throughput:
  - Latency id->ex is 1 cycle when EMPTY, or when BUSY with a concurrent pop.
  - Sustained throughput is 1 instruction/cycle while ex_ready=1.
- Ordering: strict FIFO; the skid entry is never overtaken.
- Flush (flush=1 at posedge, rst_n=1):
  - Next state EMPTY; main and skid valid cleared; ex_* payload zeroed; id_ready=1.
  - An instruction offered on the flush cycle is discarded.
  - A concurrent pop still counts as consumed by execute.
  - stall_cnt is NOT cleared.
- Bubble invariant: whenever ex_valid=0, all ex_* payload outputs equal 0. This keeps downstream logic that ignores valid safe (ex_wreg=0).
- Stall counter:
  - Increments by 1 each cycle with id_valid && !id_ready and rst_n=1, including the flush cycle.
  - Saturates at 2^STALL_CNT_W-1; never wraps.
- Reset mid-operation: all buffered instructions are lost and no partial payload appears afterwards.
- id_valid may drop without a handshake; the stage imposes no stability requirement on decode.
- Downstream rule: when ex_valid=1 and ex_ready=0, ex_* stays stable until pop or flush.

Decomposition:
- Shared package pipe_pkg holds:
  - default widths (ALUOP_W, ALUSEL_W, DATA_W, RADDR_W);
  - the state enum EMPTY/BUSY/FULL, 2-bit encoding;
  - a helper constant for the packed payload width, ALUOP_W+ALUSEL_W+2*DATA_W+RADDR_W+1.
- One natural sub-module, pipe_skid_buf:
  - generic over a packed payload width;
  - implements the state machine, flush and the zero-on-empty rule.
- id_ex_pipe packs/unpacks the fields around pipe_skid_buf and owns stall_cnt.
- pipe_skid_buf is reused for the later EX/MEM and MEM/WB stages.

Test Plan:
- Reset sequence: hold rst_n=0 for 2 edges with id_valid=1, id_aluop=7'h21 -> ex_valid=0, all ex_*=0, id_ready=1, stall_cnt=0; first edge after release with id_valid=1 loads the payload, ex_valid=1.
- Streaming: ex_ready=1, 8 back-to-back instructions reg1=0..7, wd=1..8 -> ex_reg1 sequence 0..7 one per cycle, 1-cycle latency, id_ready stays 1.
- Backpressure: ex_ready=0 with instructions A(reg1=0xA) and B(reg1=0xB) offered:
  - -> FULL, id_ready=0, ex_reg1 holds 0xA, stall_cnt increments while C is offered.
  - then ex_ready=1 -> outputs A, B, C in order with no loss or duplication.
- Flush in FULL with C offered: flush=1 -> next cycle ex_valid=0, ex_wreg=0, ex_wd=0, id_ready=1; C never appears; stall_cnt retains its value.
- Saturation with STALL_CNT_W=3: hold id_valid=1, ex_ready=0 for 20 cycles -> stall_cnt reaches 7 and stays at 7.
- Mid-stream reset: rst_n=0 for one edge while BUSY with wreg=1 -> ex_wreg=0, ex_valid=0 next cycle; normal traffic resumes on the following edge.
